cnn_conv3x3_core: RTL and testbench

//  Single 3x3 convolution engine between the PS pixel feeder and the PL result path.
//  - Collects 9 unsigned 8-bit pixels, one per rising edge of ps_pixel_valid, into a 3x3 window.
//  - Convolves the window with a fixed unsigned 3x3 kernel.
//  - Saturates the result to 8 bits and emits it with a one-cycle valid strobe.

---
 rtl/cnn_conv3x3_core.sv | 128 ++++++++++++
 tb/tb_cnn_conv3x3_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cnn_conv3x3_core.sv
// 3x3 convolution engine: edge-captured pixel window, fixed-kernel MAC, 8-bit saturation.
// Optional macro OUT_REG_EN adds one output register stage (latency 2 -> 3 clocks).
module cnn_conv3x3_core #(
    parameter int                     DATA_W = 8,
    parameter int                     ACC_W  = 16,
    parameter logic [9*DATA_W-1:0]    KERNEL = 72'h08_08_07_06_05_04_03_02_01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ps_pixel,
    input  logic              ps_pixel_valid,
    output logic [DATA_W-1:0] pl_pixel_out,
    output logic              pl_pixel_valid
);

    // rst_n is active-high despite its name.
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

    logic              valid_q;
    logic              capture;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              full_q;
    logic              full_d;
    logic [DATA_W-1:0] win_q  [9];
    logic [ACC_W-1:0]  prod   [9];
    logic [ACC_W-1:0]  sum_d;
    logic [ACC_W-1:0]  sum_q;
    logic              sum_vld_q;
    logic [DATA_W-1:0] sat_d;
    logic [DATA_W-1:0] out_q;
    logic              out_vld_q;

    assign capture = ps_pixel_valid & ~valid_q;

    always_comb begin
        cnt_d  = cnt_q;
        full_d = 1'b0;
        if (capture) begin
            if (cnt_q == 4'd8) begin
                cnt_d  = 4'd0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
            full_q  <= 1'b0;
        end else begin
            valid_q <= ps_pixel_valid;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
        end
    end

    // Window slot gi is written only on the capture that addresses it.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_win
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    win_q[gi] <= '0;
                end else if (capture && (cnt_q == 4'(gi))) begin
                    win_q[gi] <= ps_pixel;
                end
            end

            assign prod[gi] = ACC_W'(win_q[gi]) * ACC_W'(KERNEL[gi*DATA_W +: DATA_W]);
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++) begin
            sum_d = sum_d + prod[i];
        end
    end

    assign sat_d = (sum_q > SAT_MAX) ? {DATA_W{1'b1}} : sum_q[DATA_W-1:0];

    // The sum is latched at E+1, so a new frame overwriting the window from E+2 is harmless.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            sum_vld_q <= full_q;
            out_vld_q <= sum_vld_q;
            if (full_q) begin
                sum_q <= sum_d;
            end
            if (sum_vld_q) begin
                out_q <= sat_d;
            end
        end
    end

`ifdef OUT_REG_EN
    logic [DATA_W-1:0] out2_q;
    logic              out2_vld_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            out2_q     <= '0;
            out2_vld_q <= 1'b0;
        end else begin
            out2_vld_q <= out_vld_q;
            if (out_vld_q) begin
                out2_q <= out_q;
            end
        end
    end

    assign pl_pixel_out   = out2_q;
    assign pl_pixel_valid = out2_vld_q;
`else
    assign pl_pixel_out   = out_q;
    assign pl_pixel_valid = out_vld_q;
`endif

endmodule

// File: tb/tb_cnn_conv3x3_core.sv
// Self-checking bench for cnn_conv3x3_core: directed frames plus random frames vs a reference model.
module tb_cnn_conv3x3_core;

`ifdef OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef logic [7:0] frame_t [9];

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] ps_pixel = 8'd0;
    logic       ps_pixel_valid = 1'b0;
    logic [7:0] pl_pixel_out;
    logic       pl_pixel_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_e = 0;
    int pulse_val [$];
    int pulse_cyc [$];
    int weights [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 8};

    cnn_conv3x3_core dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ps_pixel       (ps_pixel),
        .ps_pixel_valid (ps_pixel_valid),
        .pl_pixel_out   (pl_pixel_out),
        .pl_pixel_valid (pl_pixel_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle in which the output strobe is seen high.
    always @(negedge clk) begin
        if (pl_pixel_valid === 1'b1) begin
            pulse_val.push_back(int'(pl_pixel_out));
            pulse_cyc.push_back(cyc);
        end
    end

    function automatic int ref_conv(input frame_t px);
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(px[i]) * weights[i];
        return (s > 255) ? 255 : s;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_pixel(input logic [7:0] p, input int hold, input int gap);
        @(negedge clk);
        ps_pixel       = p;
        ps_pixel_valid = 1'b1;
        last_e         = cyc + 1;
        repeat (hold) @(negedge clk);
        ps_pixel_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_frame(input frame_t px, input int hold, input int gap);
        for (int i = 0; i < 9; i++) send_pixel(px[i], hold, gap);
    endtask

    task automatic clear_pulses();
        pulse_val.delete();
        pulse_cyc.delete();
    endtask

    // Send one frame, wait out the pipeline, expect exactly one pulse of the model's value.
    task automatic run_frame(input string tag, input frame_t px, input int hold, input int gap);
        int e;
        clear_pulses();
        send_frame(px, hold, gap);
        e = last_e;
        repeat (8) @(negedge clk);
        check({tag, "_count"}, pulse_val.size(), 1);
        check({tag, "_value"}, (pulse_val.size() > 0) ? pulse_val[0] : -1, ref_conv(px));
        check({tag, "_latency"}, (pulse_cyc.size() > 0) ? pulse_cyc[0] - e : -1, LAT);
        $display("frame %s: pulses=%0d out=%0d expected=%0d", tag, pulse_val.size(),
                 (pulse_val.size() > 0) ? pulse_val[0] : -1, ref_conv(px));
    endtask

    initial begin
        frame_t ones, seq, center, corner, ff5, rnd;
        int e1, e2, kept;
        for (int i = 0; i < 9; i++) begin
            ones[i]   = 8'd1;
            seq[i]    = 8'(i + 1);
            center[i] = 8'd0;
            corner[i] = 8'd0;
            ff5[i]    = 8'hFF;
        end
        center[4] = 8'd10;
        corner[0] = 8'd10;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_out", int'(pl_pixel_out), 0);
        check("reset_valid", int'(pl_pixel_valid), 0);

        run_frame("T1_ones", ones, 2, 1);
        run_frame("T2_sat", seq, 1, 2);
        run_frame("T3_center", center, 1, 1);
        check("T3_hold_out", int'(pl_pixel_out), 50);
        run_frame("T3_corner", corner, 2, 3);
        run_frame("T4_level", ones, 10, 2);

        // Reset mid-frame discards partial 0xFF pixels.
        clear_pulses();
        for (int i = 0; i < 5; i++) send_pixel(8'hFF, 1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("T5_out_cleared", int'(pl_pixel_out), 0);
        run_frame("T5_after_reset", ones, 1, 1);

        // Back-to-back: second frame starts at the earliest legal capture.
        clear_pulses();
        send_frame(ones, 1, 1);
        e1 = last_e;
        send_frame(seq, 1, 1);
        e2 = last_e;
        repeat (8) @(negedge clk);
        check("T6_count", pulse_val.size(), 2);
        check("T6_value0", (pulse_val.size() > 0) ? pulse_val[0] : -1, 44);
        check("T6_value1", (pulse_val.size() > 1) ? pulse_val[1] : -1, 255);
        check("T6_latency0", (pulse_cyc.size() > 0) ? pulse_cyc[0] - e1 : -1, LAT);
        check("T6_latency1", (pulse_cyc.size() > 1) ? pulse_cyc[1] - e2 : -1, LAT);
        $display("frame T6: pulses=%0d", pulse_val.size());

        // Reset one cycle after the pixel-8 capture drops the result in flight.
        clear_pulses();
        for (int i = 0; i < 8; i++) send_pixel(8'd3, 1, 1);
        @(negedge clk);
        ps_pixel       = 8'd3;
        ps_pixel_valid = 1'b1;
        @(negedge clk);
        ps_pixel_valid = 1'b0;
        rst_n          = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (8) @(negedge clk);
        check("T7_dropped_count", pulse_val.size(), 0);
        check("T7_out_cleared", int'(pl_pixel_out), 0);
        $display("frame T7: pulses=%0d", pulse_val.size());

        // Random frames: mix small and full-range pixels to hit both sides of saturation.
        for (int f = 0; f < 6; f++) begin
            kept = $urandom_range(0, 1);
            for (int i = 0; i < 9; i++)
                rnd[i] = (kept != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
            run_frame($sformatf("R%0d", f), rnd, $urandom_range(1, 4), $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
